// File: rtl/riscv_irq_pkg.sv
// Shared types and constants for the interrupt arbiter.
// State encoding, CSR addresses and the interrupt ID width.
package riscv_irq_pkg;

  localparam int IRQ_ID_W = 5;

  typedef logic [1:0] irq_state_t;

  localparam irq_state_t IRQ_IDLE   = 2'd0;
  localparam irq_state_t IRQ_REQ    = 2'd1;
  localparam irq_state_t IRQ_ACTIVE = 2'd2;

  localparam logic [1:0] IRQ_REG_ENABLE  = 2'd0;
  localparam logic [1:0] IRQ_REG_EDGE    = 2'd1;
  localparam logic [1:0] IRQ_REG_PENDING = 2'd2;
  localparam logic [1:0] IRQ_REG_STATUS  = 2'd3;

endpackage

// File: rtl/riscv_irq_prio_enc.sv
// Priority encoder with a rotating start index: returns the first set
// request at or after start_i, wrapping from NUM_SRC-1 back to 0.
module riscv_irq_prio_enc
  import riscv_irq_pkg::*;
#(
  parameter int NUM_SRC = 32
) (
  input  logic [NUM_SRC-1:0]  req_i,
  input  logic [IRQ_ID_W-1:0] start_i,
  output logic                valid_o,
  output logic [IRQ_ID_W-1:0] id_o
);

  logic [IRQ_ID_W:0] idx_s;

  // Scan from the farthest offset down so the nearest hit is the last write.
  always_comb begin
    valid_o = 1'b0;
    id_o    = '0;
    idx_s   = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx_s = {1'b0, start_i} + 6'(k);
      if (idx_s >= 6'(NUM_SRC)) begin
        idx_s = idx_s - 6'(NUM_SRC);
      end else begin
        idx_s = idx_s;
      end
      if (req_i[idx_s[IRQ_ID_W-1:0]]) begin
        valid_o = 1'b1;
        id_o    = idx_s[IRQ_ID_W-1:0];
      end else begin
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/riscv_irq_arbiter.sv
// Interrupt arbiter/sequencer: mask, latch, select and hold one interrupt
// until eret. Define IRQ_ARB_ROUND_ROBIN_EN for round-robin arbitration.
module riscv_irq_arbiter
  import riscv_irq_pkg::*;
#(
  parameter int NUM_SRC = 32,
  parameter int ID_W    = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic               cfg_we_i,
  input  logic [1:0]         cfg_addr_i,
  input  logic [31:0]        cfg_wdata_i,
  output logic [31:0]        cfg_rdata_o,
  output logic [31:0]        irq_o,
  output logic [ID_W-1:0]    irq_id_o,
  input  logic               ack_i,
  input  logic               done_i,
  output logic               busy_o
);

  logic [NUM_SRC-1:0]  enable_q, enable_d, edge_q, edge_d;
  logic [NUM_SRC-1:0]  pend_q, pend_d, src_q;
  logic [NUM_SRC-1:0]  pend_s, cand_s, sw_clr_s, ack_clr_s, wdata_s;
  irq_state_t          state_q, state_d;
  logic [IRQ_ID_W-1:0] grant_q, grant_d, start_s, win_id_s;
  logic [31:0]         irq_q, irq_d;
  logic                win_valid_s, ack_take_s;

  assign wdata_s    = cfg_wdata_i[NUM_SRC-1:0];
  assign ack_take_s = (state_q == IRQ_REQ) && ack_i;
  // Edge sources read their latch, level sources read the pin directly.
  assign pend_s     = (edge_q & pend_q) | (~edge_q & src_i);
  assign cand_s     = pend_s & enable_q;
  assign ack_clr_s  = ack_take_s ? (NUM_SRC'(1) << grant_q) : '0;

  // CSR write decode
  always_comb begin
    enable_d = enable_q;
    edge_d   = edge_q;
    sw_clr_s = '0;
    if (cfg_we_i) begin
      case (cfg_addr_i)
        IRQ_REG_ENABLE:  enable_d = wdata_s;
        IRQ_REG_EDGE:    edge_d   = wdata_s;
        IRQ_REG_PENDING: sw_clr_s = wdata_s;
        default:         sw_clr_s = '0;
      endcase
    end else begin
      sw_clr_s = '0;
    end
  end

  // New rising edges are OR-ed in after clears, so a same-cycle set wins.
  assign pend_d = ((pend_q & ~(sw_clr_s | ack_clr_s)) | (edge_q & src_i & ~src_q)) & edge_q;

`ifdef IRQ_ARB_ROUND_ROBIN_EN
  logic [IRQ_ID_W-1:0] rr_q, rr_d;

  assign start_s = rr_q;

  // Round-robin pointer moves past the source just accepted
  always_comb begin
    if (ack_take_s) begin
      rr_d = (grant_q == IRQ_ID_W'(NUM_SRC - 1)) ? '0 : grant_q + 5'd1;
    end else begin
      rr_d = rr_q;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_q <= '0;
    else        rr_q <= rr_d;
  end
`else
  assign start_s = '0;
`endif

  riscv_irq_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio_enc (
    .req_i   (cand_s),
    .start_i (start_s),
    .valid_o (win_valid_s),
    .id_o    (win_id_s)
  );

  // Sequencer: grant is locked in REQ; ack beats retract
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      IRQ_IDLE: begin
        if (win_valid_s) begin
          state_d = IRQ_REQ;
          grant_d = win_id_s;
        end else begin
          state_d = IRQ_IDLE;
        end
      end
      IRQ_REQ: begin
        if (ack_i)                 state_d = IRQ_ACTIVE;
        else if (!cand_s[grant_q]) state_d = IRQ_IDLE;
        else                       state_d = IRQ_REQ;
      end
      IRQ_ACTIVE: begin
        if (done_i) state_d = IRQ_IDLE;
        else        state_d = IRQ_ACTIVE;
      end
      default: state_d = IRQ_IDLE;
    endcase
    irq_d = (state_d == IRQ_REQ) ? (32'd1 << grant_d) : 32'd0;
  end

  // State, configuration and pending registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q <= '0;
      edge_q   <= '0;
      pend_q   <= '0;
      src_q    <= '0;
      state_q  <= IRQ_IDLE;
      grant_q  <= '0;
      irq_q    <= 32'd0;
    end else begin
      enable_q <= enable_d;
      edge_q   <= edge_d;
      pend_q   <= pend_d;
      src_q    <= src_i;
      state_q  <= state_d;
      grant_q  <= grant_d;
      irq_q    <= irq_d;
    end
  end

  assign irq_o    = irq_q;
  assign irq_id_o = grant_q;
  assign busy_o   = (state_q != IRQ_IDLE);

  // CSR read mux
  always_comb begin
    case (cfg_addr_i)
      IRQ_REG_ENABLE:  cfg_rdata_o = 32'(enable_q);
      IRQ_REG_EDGE:    cfg_rdata_o = 32'(edge_q);
      IRQ_REG_PENDING: cfg_rdata_o = 32'(cand_s);
      default:         cfg_rdata_o = {busy_o, 26'd0, grant_q};
    endcase
  end

endmodule

// File: tb/tb_riscv_irq_arbiter.sv
// Self-checking bench for riscv_irq_arbiter: directed scenarios plus
// random stimulus against a cycle-level behavioural model.
module tb_riscv_irq_arbiter;

  localparam int NUM     = 32;
  localparam int PH_IDLE = 0;
  localparam int PH_REQ  = 1;
  localparam int PH_ACT  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] src;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic [31:0] irq_o;
  logic [4:0]  irq_id;
  logic        ack, done, busy;

  int checks = 0;
  int errors = 0;

  // Model: per-source configuration, latched edges, and where the one
  // in-flight interrupt currently is.
  bit [31:0] m_ena, m_edg, m_lat, m_prev;
  int        m_phase, m_gid, m_rr;

  riscv_irq_arbiter #(.NUM_SRC(NUM), .ID_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .src_i       (src),
    .cfg_we_i    (cfg_we),
    .cfg_addr_i  (cfg_addr),
    .cfg_wdata_i (cfg_wdata),
    .cfg_rdata_o (cfg_rdata),
    .irq_o       (irq_o),
    .irq_id_o    (irq_id),
    .ack_i       (ack),
    .done_i      (done),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit [31:0] m_cand();
    bit [31:0] s;
    s = src;
    return m_ena & ((m_edg & m_lat) | (~m_edg & s));
  endfunction

  function automatic void model_reset();
    m_ena = 0; m_edg = 0; m_lat = 0; m_prev = 0;
    m_phase = PH_IDLE; m_gid = 0; m_rr = 0;
  endfunction

  function automatic void model_step();
    bit [31:0] cand, clr, setb, s;
    bit        any;
    int        win, i, nphase, ngid, nrr;
    s = src;
    cand = m_cand();
    any = 1'b0; win = 0;
    for (int k = 0; k < NUM; k++) begin
      i = (m_rr + k) % NUM;
      if (!any && cand[i]) begin any = 1'b1; win = i; end
    end
    setb = m_edg & s & ~m_prev;
    clr  = (cfg_we && cfg_addr == 2'd2) ? cfg_wdata : 32'd0;
    if (m_phase == PH_REQ && ack) clr[m_gid] = 1'b1;
    nphase = m_phase; ngid = m_gid; nrr = m_rr;
    if (m_phase == PH_IDLE && any) begin
      nphase = PH_REQ; ngid = win;
    end else if (m_phase == PH_REQ && ack) begin
      nphase = PH_ACT;
`ifdef IRQ_ARB_ROUND_ROBIN_EN
      nrr = (m_gid + 1) % NUM;
`endif
    end else if (m_phase == PH_REQ && !cand[m_gid]) begin
      nphase = PH_IDLE;
    end else if (m_phase == PH_ACT && done) begin
      nphase = PH_IDLE;
    end
    m_lat = ((m_lat & ~clr) | setb) & m_edg;
    if (cfg_we && cfg_addr == 2'd0) m_ena = cfg_wdata;
    if (cfg_we && cfg_addr == 2'd1) m_edg = cfg_wdata;
    m_prev = s; m_phase = nphase; m_gid = ngid; m_rr = nrr;
  endfunction

  task automatic compare_all();
    bit [31:0] exp_rd;
    chk("irq", irq_o, (m_phase == PH_REQ) ? (32'd1 << m_gid) : 32'd0);
    chk("irq_id", 32'(irq_id), 32'(m_gid));
    chk("busy", 32'(busy), (m_phase != PH_IDLE) ? 32'd1 : 32'd0);
    case (cfg_addr)
      2'd0:    exp_rd = m_ena;
      2'd1:    exp_rd = m_edg;
      2'd2:    exp_rd = m_cand();
      default: exp_rd = {(m_phase != PH_IDLE), 26'd0, 5'(m_gid)};
    endcase
    chk("rdata", cfg_rdata, exp_rd);
  endtask

  // One clock: compare before the edge, advance model on the edge.
  task automatic step();
    #1;
    compare_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    step();
    cfg_we = 1'b0; cfg_wdata = 32'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; src = 0; cfg_we = 0; cfg_addr = 0; cfg_wdata = 0; ack = 0; done = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_irq", irq_o, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_id", 32'(irq_id), 32'd0);
    rst_n = 1'b1;
  endtask

  int seq_exp [3] = '{1, 30, 1};
  int bit_sel;

  initial begin
    do_reset();

    // Level source 3
    wr(2'd0, 32'h8);
    src = 32'h8;
    step();
    chk("lvl_irq", irq_o, 32'h8);
    chk("lvl_id", 32'(irq_id), 32'd3);
    ack = 1'b1; step(); ack = 1'b0;
    chk("lvl_ack_irq", irq_o, 32'd0);
    chk("lvl_ack_busy", 32'(busy), 32'd1);
    done = 1'b1; src = 32'd0; step(); done = 1'b0;
    chk("lvl_done_busy", 32'(busy), 32'd0);

    // Simultaneous edges on 2 and 5
    do_reset();
    wr(2'd0, 32'h24);
    wr(2'd1, 32'h24);
    src = 32'h24; cfg_addr = 2'd2;
    step();
    chk("edge_pend_both", cfg_rdata, 32'h24);
    chk("edge_not_yet", 32'(busy), 32'd0);
    step();
    chk("edge_first_id", 32'(irq_id), 32'd2);
    chk("edge_first_irq", irq_o, 32'h4);
    ack = 1'b1; step(); ack = 1'b0;
    chk("edge_pend_after1", cfg_rdata, 32'h20);
    done = 1'b1; step(); done = 1'b0;
    chk("edge_idle", 32'(busy), 32'd0);
    step();
    chk("edge_second_id", 32'(irq_id), 32'd5);
    ack = 1'b1; step(); ack = 1'b0;
    chk("edge_pend_after2", cfg_rdata, 32'h0);
    done = 1'b1; step(); done = 1'b0;

    // Lock-in: higher-priority arrival does not preempt
    do_reset();
    wr(2'd0, 32'h81);
    src = 32'h80; step();
    chk("lock_id0", 32'(irq_id), 32'd7);
    src = 32'h81; step();
    chk("lock_id1", 32'(irq_id), 32'd7);
    step();
    chk("lock_irq", irq_o, 32'h80);
    ack = 1'b1; step(); ack = 1'b0;
    chk("lock_ack_busy", 32'(busy), 32'd1);
    src = 32'd0; done = 1'b1; step(); done = 1'b0;

    // Retract
    do_reset();
    wr(2'd0, 32'h10);
    src = 32'h10; step();
    chk("retr_irq", irq_o, 32'h10);
    src = 32'd0; step();
    chk("retr_irq0", irq_o, 32'd0);
    chk("retr_idle", 32'(busy), 32'd0);

`ifdef IRQ_ARB_ROUND_ROBIN_EN
    // Round-robin alternation between 1 and 30
    do_reset();
    wr(2'd0, 32'h4000_0002);
    src = 32'h4000_0002;
    for (int r = 0; r < 3; r++) begin
      step();
      chk("rr_id", 32'(irq_id), 32'(seq_exp[r]));
      ack = 1'b1; step(); ack = 1'b0;
      done = 1'b1; step(); done = 1'b0;
    end
    src = 32'd0;
`endif

    // Reset in the middle of a request
    do_reset();
    wr(2'd0, 32'h30);
    wr(2'd1, 32'h20);
    src = 32'h30; step();
    chk("mid_irq", irq_o, 32'h10);
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_irq", irq_o, 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_id", 32'(irq_id), 32'd0);
    do_reset();
    cfg_addr = 2'd2; #1;
    chk("mid_rst_pend", cfg_rdata, 32'd0);
    step();

    // Random traffic
    do_reset();
    wr(2'd0, $urandom());
    wr(2'd1, $urandom());
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        bit_sel = $urandom_range(0, NUM - 1);
        src[bit_sel] = ~src[bit_sel];
      end
      ack       = ($urandom_range(0, 2) == 0);
      done      = ($urandom_range(0, 2) == 0);
      cfg_we    = ($urandom_range(0, 11) == 0);
      cfg_addr  = 2'($urandom_range(0, 3));
      cfg_wdata = $urandom();
      step();
    end
    cfg_we = 1'b0; ack = 1'b0; done = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
